// File: rtl/ifu_pkg.sv
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
//            Provides the fetch FSM state encoding, the prefetch entry
//            layout and the default reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0200_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } ifu_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               fault;
  } ifu_entry_t;

  localparam int ENTRY_W = $bits(ifu_entry_t);

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module   : ifu_fifo
// Purpose  : Synchronous prefetch FIFO holding fetched entries.
//            flush dominates push and pop; a push into a full FIFO is
//            accepted only when a pop frees a slot in the same cycle.
// Ports    : clk, rst_n        - clock, async active-low reset
//            flush             - drop all entries
//            push, push_data   - write an entry
//            pop               - consume the head entry
//            head              - current head entry (stale when empty)
//            full, empty, count- occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     push_data,
  input  logic                   pop,
  output logic [ENTRY_W-1:0]     head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front end. Holds the fetch PC, issues word
//            reads over a req/gnt/rvalid handshake (one outstanding at most),
//            buffers returned words with their PC in a prefetch FIFO and
//            presents the head to the decoder. A redirect flushes the FIFO
//            and restarts fetch at the target.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            redirect_valid/pc          - restart fetch at redirect_pc
//            imem_req/addr/gnt          - request side of the memory port
//            imem_rvalid/rdata/err      - response side of the memory port
//            instruction_code/instr_pc  - FIFO head, zero when empty
//            en, dec_ready              - head valid / head consumed
//            fetch_fault                - head is a fault entry
//            fetch_cnt, stall_cnt       - perf counters (IFU_PERF_CNT_EN)
// Macros   : IFU_PERF_CNT_EN - adds fetch/stall performance counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instruction_code,
  output logic [31:0] instr_pc,
  output logic        en,
  output logic        fetch_fault,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  input  logic        dec_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e         state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               drop_q, drop_d;
  logic               flt_pend_q, flt_pend_d;

  logic               fifo_flush, fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] head_bits;
  ifu_entry_t         push_entry, head_entry;
  logic               room, granted, redirect_misaligned;

  // Occupancy plus the in-flight request must leave a free slot, so the
  // returning word can always be pushed.
  assign room = (int'(fifo_count) + int'(state_q == ST_WAIT)) < FIFO_DEPTH;

  // drop_q masks the request for one cycle after a redirect so the address
  // is never swapped under a pending, ungranted request.
  assign imem_req  = (state_q == ST_REQ) && room && !drop_q;
  assign imem_addr = (state_q == ST_REQ) ? fetch_pc_q : '0;
  assign granted   = imem_req && imem_gnt;

  assign redirect_misaligned = is_misaligned(redirect_pc);

  assign en               = !fifo_empty;
  assign fifo_pop         = en && dec_ready;
  assign head_entry       = ifu_entry_t'(head_bits);
  assign instruction_code = en ? head_entry.instr : '0;
  assign instr_pc         = en ? head_entry.pc    : '0;
  assign fetch_fault      = en && head_entry.fault;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = redirect_valid;
    flt_pend_d = 1'b0;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    push_entry = '0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (granted) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          fifo_push        = 1'b1;
          push_entry.instr = imem_err ? '0 : imem_rdata;
          push_entry.pc    = req_pc_q;
          push_entry.fault = imem_err;
          state_d          = imem_err ? ST_HALT : ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      ST_HALT: begin
        // Misaligned-redirect fault is pushed one cycle late because the
        // redirect cycle itself flushes the FIFO.
        if (flt_pend_q) begin
          fifo_push        = 1'b1;
          push_entry.instr = '0;
          push_entry.pc    = fetch_pc_q;
          push_entry.fault = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fetch_pc_d = redirect_pc;
      if (redirect_misaligned) begin
        state_d    = ST_HALT;
        flt_pend_d = 1'b1;
      end else if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !imem_rvalid) begin
        state_d = ST_DRAIN;
      end else if (granted) begin
        // Granted this very cycle: its response is still to come.
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      flt_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      flt_pend_q <= flt_pend_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fifo_pop};
    stall_cnt_d = stall_cnt_q + {31'd0, (!en && (state_q != ST_HALT))};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit. A memory responder
//            grants requests and returns words; expected request addresses
//            and expected decoder entries are queued by the directed tests
//            and compared by the responder and a pop monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic [31:0] instruction_code;
  logic [31:0] instr_pc;
  logic        en;
  logic        fetch_fault;
  logic        dec_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          failures = 0;
  int          grant_budget = 0;
  int          extra_delay = 0;
  int          grants = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          delay_left = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .imem_err         (imem_err),
    .instruction_code (instruction_code),
    .instr_pc         (instr_pc),
    .en               (en),
    .fetch_fault      (fetch_fault),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt        (fetch_cnt),
    .stall_cnt        (stall_cnt),
`endif
    .dec_ready        (dec_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0200_0000: return 32'h0000_0797;
      32'h0200_0004: return 32'h02c7_8793;
      32'h0200_0100: return 32'h1a50_00ef;
      default:       return {a[15:0], 16'h0013};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s: timeout with %0d entries and %0d requests pending, required 0 and 0",
               name, exp_q.size(), addr_q.size());
    end
  endtask

  task automatic wait_grant(input string name, input int limit);
    int g0 = grants;
    int n  = 0;
    while (grants == g0 && n < limit) begin
      step();
      n++;
    end
    check(name, 32'(grants - g0), 32'd1);
  endtask

  // Memory responder: grants while budget remains, returns data after
  // extra_delay idle cycles, flags imem_err for err_addr.
  initial begin : responder
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_err    = 1'b0;
      imem_rdata  = '0;
      if (pend) begin
        if (delay_left == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          imem_err    = (pend_addr == err_addr);
          pend        = 1'b0;
        end else begin
          delay_left--;
        end
      end
      imem_gnt = 1'b0;
      if (imem_req && !pend && grant_budget > 0) begin
        imem_gnt   = 1'b1;
        pend       = 1'b1;
        pend_addr  = imem_addr;
        delay_left = extra_delay;
        grant_budget--;
        grants++;
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_addr: got unexpected request at %h required none", imem_addr);
        end else begin
          check("req_addr", imem_addr, addr_q.pop_front());
        end
      end
    end
  end

  // Pop monitor: every consumed head must match the next expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && en && dec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop: got unexpected code=%h pc=%h fault=%b required no entry",
                   instruction_code, instr_pc, fetch_fault);
        end else begin
          e = exp_q.pop_front();
          if ({instruction_code, instr_pc, fetch_fault} !== e) begin
            failures++;
            $display("FAIL pop: got code=%h pc=%h fault=%b required code=%h pc=%h fault=%b",
                     instruction_code, instr_pc, fetch_fault, e.code, e.pc, e.fault);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int g0;
    step();
    step();

    // Reset state
    check("rst_imem_req",   {31'd0, imem_req},    32'd0);
    check("rst_imem_addr",  imem_addr,            32'd0);
    check("rst_en",         {31'd0, en},          32'd0);
    check("rst_code",       instruction_code,     32'd0);
    check("rst_instr_pc",   instr_pc,             32'd0);
    check("rst_fault",      {31'd0, fetch_fault}, 32'd0);

    // Basic fetch after reset release
    addr_q.push_back(32'h0200_0000);
    addr_q.push_back(32'h0200_0004);
    exp_q.push_back('{32'h0000_0797, 32'h0200_0000, 1'b0});
    exp_q.push_back('{32'h02c7_8793, 32'h0200_0004, 1'b0});
    grant_budget = 2;
    dec_ready    = 1'b1;
    rst_n        = 1'b1;
    #1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    wait_drain("basic_fetch", 40);

    // Backpressure: exactly FIFO_DEPTH words fetched, head held
    dec_ready = 1'b0;
    redirect(32'h0200_0000);
    addr_q.push_back(32'h0200_0000);
    addr_q.push_back(32'h0200_0004);
    g0 = grants;
    grant_budget = 10;
    repeat (10) step();
    check("bp_grants",  32'(grants - g0),       32'd2);
    check("bp_req_low", {31'd0, imem_req},      32'd0);
    check("bp_en",      {31'd0, en},            32'd1);
    check("bp_head",    instruction_code,       32'h0000_0797);
    check("bp_head_pc", instr_pc,               32'h0200_0000);
    grant_budget = 0;
    exp_q.push_back('{32'h0000_0797, 32'h0200_0000, 1'b0});
    exp_q.push_back('{32'h02c7_8793, 32'h0200_0004, 1'b0});
    dec_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Redirect while a response is outstanding
    addr_q.push_back(32'h0200_0008);
    extra_delay  = 3;
    grant_budget = 1;
    wait_grant("wait_granted", 20);
    redirect(32'h0200_09c4);
    check("redir_en_low", {31'd0, en}, 32'd0);
    extra_delay = 0;
    addr_q.push_back(32'h0200_09c4);
    exp_q.push_back('{32'h09c4_0013, 32'h0200_09c4, 1'b0});
    grant_budget = 1;
    wait_drain("redir_fetch", 40);

    // Bus error halts fetch
    err_addr = 32'h0200_0010;
    redirect(32'h0200_0010);
    addr_q.push_back(32'h0200_0010);
    exp_q.push_back('{32'h0000_0000, 32'h0200_0010, 1'b1});
    grant_budget = 1;
    wait_drain("err_entry", 40);
    repeat (6) begin
      step();
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
    end
    check("halt_en_low", {31'd0, en}, 32'd0);

    // Misaligned redirect: fault entry, no request
    exp_q.push_back('{32'h0000_0000, 32'h0200_0002, 1'b1});
    redirect(32'h0200_0002);
    repeat (6) begin
      check("mis_no_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    wait_drain("mis_entry", 20);

    // Reset during WAIT; stray response after release is ignored
    addr_q.push_back(32'h0200_0100);
    redirect(32'h0200_0100);
    extra_delay  = 5;
    grant_budget = 1;
    wait_grant("pre_reset_grant", 20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_en",  {31'd0, en},       32'd0);
    extra_delay = 0;
    addr_q.push_back(32'h0200_0000);
    exp_q.push_back('{32'h0000_0797, 32'h0200_0000, 1'b0});
    grant_budget = 1;
    step();
    step();
    rst_n = 1'b1;
    wait_drain("post_reset_fetch", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
